// File: rtl/instr_issue_unit.sv
// instr_issue_unit: fetches Thumb halfwords, issues them to controlunit and injects self-instructions.
// Optional issued-word counter enabled by defining ISSUE_CNT_EN.
module instr_issue_unit #(
  parameter int ADDR_W     = 10,
  parameter int START_ADDR = 0,
  parameter int INJ_MAX    = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic              imem_rd_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [15:0]       imem_data_i,
  output logic [15:0]       instr_o,
  output logic              instr_valid_o,
  input  logic              branch_i,
  input  logic              self_instr_en_i,
  input  logic [15:0]       self_instr_i,
  input  logic              stall_self_i,
  input  logic              end_program_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic              err_o,
  output logic [31:0]       issue_cnt_o
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ISSUE, INJECT, HALT} state_t;
  localparam int CW = $clog2(INJ_MAX + 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_next;
  logic [15:0] instr_q, instr_d, inj_q, inj_d;
  logic [CW-1:0] inj_cnt, cnt_d;
  logic err_q, err_d, stall_req;
  assign stall_req = self_instr_en_i && stall_self_i;
  // Taken conditional branch uses imm8, unconditional B uses imm11; both relative to pc+2
  assign pc_next = branch_i ? ADDR_W'(32'(pc_q) + 32'd2 + {{24{instr_q[7]}}, instr_q[7:0]})
                 : instr_q[15:11] == 5'b11100 ? ADDR_W'(32'(pc_q) + 32'd2 + {{21{instr_q[10]}}, instr_q[10:0]})
                 : pc_q + ADDR_W'(1);
  assign imem_rd_o     = state_q == FETCH;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = state_q == ISSUE || state_q == INJECT;
  assign instr_o       = state_q == ISSUE ? instr_q : state_q == INJECT ? inj_q : '0;
  assign busy_o        = state_q == FETCH || state_q == CAPTURE || state_q == ISSUE || state_q == INJECT;
  assign halted_o      = state_q == HALT;
  assign err_o         = err_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    inj_d   = inj_q;
    cnt_d   = inj_cnt;
    err_d   = err_q;
    case (state_q)
      IDLE, HALT: if (start_i) begin
        state_d = FETCH;
        pc_d    = ADDR_W'(START_ADDR);
        err_d   = 1'b0;
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        instr_d = imem_data_i;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = end_program_i ? HALT : stall_req ? INJECT : FETCH;
        pc_d    = end_program_i ? pc_q : pc_next;
        inj_d   = (!end_program_i && stall_req) ? self_instr_i : inj_q;
        cnt_d   = (!end_program_i && stall_req) ? CW'(1) : inj_cnt;
      end
      INJECT: begin
        if (end_program_i) begin
          state_d = HALT;
          cnt_d   = '0;
        end else if (stall_req && 32'(inj_cnt) < INJ_MAX) begin
          inj_d = self_instr_i;
          cnt_d = inj_cnt + CW'(1);
        end else if (stall_req) begin
          err_d   = 1'b1;
          state_d = HALT;
          cnt_d   = '0;
        end else begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q    <= ADDR_W'(START_ADDR);
      instr_q <= '0;
      inj_q   <= '0;
      inj_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      inj_q   <= inj_d;
      inj_cnt <= cnt_d;
      err_q   <= err_d;
    end
  end
`ifdef ISSUE_CNT_EN
  logic [31:0] cnt_q;
  logic start_ok;
  assign start_ok = (state_q == IDLE || state_q == HALT) && start_i;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else if (start_ok) cnt_q <= '0;
    else if (instr_valid_o) cnt_q <= cnt_q + 32'd1;
  end
  assign issue_cnt_o = cnt_q;
`else
  assign issue_cnt_o = '0;
`endif
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: program-walk model of the issue unit checked cycle by cycle, plus literal pins.
module tb_instr_issue_unit;
  logic clk_i = 0, rst_n_i = 0, start_i = 0;
  logic imem_rd_o, instr_valid_o, branch_i, self_instr_en_i, stall_self_i, end_program_i;
  logic busy_o, halted_o, err_o;
  logic [9:0] imem_addr_o;
  logic [15:0] imem_data_i = '0, instr_o, self_instr_i;
  logic [31:0] issue_cnt_o;
  instr_issue_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .imem_rd_o(imem_rd_o),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i), .instr_o(instr_o),
    .instr_valid_o(instr_valid_o), .branch_i(branch_i), .self_instr_en_i(self_instr_en_i),
    .self_instr_i(self_instr_i), .stall_self_i(stall_self_i), .end_program_i(end_program_i),
    .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o), .issue_cnt_o(issue_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  logic [15:0] mem [1024];
  always @(posedge clk_i) if (imem_rd_o) imem_data_i <= mem[imem_addr_o];
  // Controlunit stub: responses are pure functions of the presented word and the run's valid index
  int stop_after = 1000, vcount = 0;
  always @(posedge clk_i) if (start_i && !busy_o) vcount <= 0; else if (instr_valid_o) vcount <= vcount + 1;
  function automatic logic f_br(input logic [15:0] w); return w[15:12] == 4'hD; endfunction
  function automatic logic f_req(input logic [15:0] w); return w[15:8] == 8'hB4; endfunction
  function automatic logic f_stall(input logic [15:0] w); return w[15:8] == 8'hB4 && w[7:0] != 8'h01; endfunction
  function automatic logic [15:0] f_self(input logic [15:0] w);
    return w == 16'hB480 ? 16'h9701 : w == 16'hB4FF ? 16'hB4FF : 16'h1234;
  endfunction
  assign branch_i        = instr_valid_o && f_br(instr_o);
  assign self_instr_en_i = instr_valid_o && f_req(instr_o);
  assign stall_self_i    = instr_valid_o && f_stall(instr_o);
  assign self_instr_i    = instr_valid_o ? f_self(instr_o) : 16'h0;
  assign end_program_i   = instr_valid_o && (instr_o == 16'hDF00 || vcount == stop_after);
  typedef struct packed {
    logic rd; logic [9:0] addr; logic valid; logic [15:0] instr;
    logic busy, halted, err; logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, fails = 0, pop_n = 0, first_v = 0;
  logic [9:0] seen_rd[$];
  logic [15:0] seen_val[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic rd, input int addr, input logic valid, input logic [15:0] w,
                      input logic busy, input logic halted, input logic err, input int cnt);
    q.push_back('{rd, 10'(addr), valid, w, busy, halted, err, 32'(cnt)});
  endtask
  // Walk the program the way the spec describes: 3 cycles per word, injected words after it
  task automatic build(input int stop);
    int pc = 0, k = 0, n = 0, j;
    logic err = 0, done = 0, e_now;
    logic [15:0] w, cur;
    for (int it = 0; it < 60 && !done; it++) begin
      push(1, pc, 0, 0, 1, 0, 0, n);
      push(0, pc, 0, 0, 1, 0, 0, n);
      w = mem[pc];
      push(0, pc, 1, w, 1, 0, 0, n);
      n++;
      e_now = (w == 16'hDF00 || k == stop);
      k++;
      if (e_now) begin done = 1; break; end
      if (f_br(w)) pc = (pc + 2 + int'($signed(w[7:0]))) & 1023;
      else if (w[15:11] == 5'b11100) pc = (pc + 2 + int'($signed(w[10:0]))) & 1023;
      else pc = (pc + 1) & 1023;
      if (f_req(w) && f_stall(w)) begin
        cur = f_self(w);
        j = 1;
        forever begin
          push(0, pc, 1, cur, 1, 0, 0, n);
          n++;
          e_now = (cur == 16'hDF00 || k == stop);
          k++;
          if (e_now) begin done = 1; break; end
          if (!(f_req(cur) && f_stall(cur))) break;
          if (j >= 8) begin err = 1; done = 1; break; end
          j++;
          cur = f_self(cur);
        end
      end
    end
    repeat (4) push(0, pc, 0, 0, 0, 1, err, n);
  endtask
  always @(posedge clk_i) begin
    #1;
    if (!rst_n_i) q.delete();
    else if (q.size() > 0) begin
      e = q.pop_front();
      pop_n++;
      if (imem_rd_o) seen_rd.push_back(imem_addr_o);
      if (instr_valid_o) begin
        seen_val.push_back(instr_o);
        if (first_v == 0) first_v = pop_n;
      end
      chk("imem_rd", 32'(imem_rd_o), 32'(e.rd));
      chk("imem_addr", 32'(imem_addr_o), 32'(e.addr));
      chk("instr_valid", 32'(instr_valid_o), 32'(e.valid));
      chk("instr", 32'(instr_o), 32'(e.instr));
      chk("busy", 32'(busy_o), 32'(e.busy));
      chk("halted", 32'(halted_o), 32'(e.halted));
      chk("err", 32'(err_o), 32'(e.err));
`ifdef ISSUE_CNT_EN
      chk("issue_cnt", issue_cnt_o, e.cnt);
`else
      chk("issue_cnt", issue_cnt_o, 32'd0);
`endif
    end
  end
  task automatic check_reset(input string tag);
    chk({tag, "_rd"}, 32'(imem_rd_o), 0);
    chk({tag, "_addr"}, 32'(imem_addr_o), 0);
    chk({tag, "_valid"}, 32'(instr_valid_o), 0);
    chk({tag, "_instr"}, 32'(instr_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_halted"}, 32'(halted_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_cnt"}, issue_cnt_o, 0);
  endtask
  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 16'hDF00;
  endtask
  task automatic run(input int stop, input int pulse_at);
    @(negedge clk_i);
    stop_after = stop;
    seen_rd.delete();
    seen_val.delete();
    pop_n = 0;
    first_v = 0;
    build(stop);
    start_i = 1;
    @(negedge clk_i);
    for (int i = 0; i < 400 && q.size() > 0; i++) begin
      start_i = (i == pulse_at);
      @(negedge clk_i);
    end
    start_i = 0;
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL run_timeout: %0d expected cycles left, required 0", q.size());
      q.delete();
    end
  endtask
  initial begin
    clear_mem();
    repeat (2) @(negedge clk_i);
    check_reset("reset");
    rst_n_i = 1;
    // Sequential, unconditional B, taken Bcc, PUSH injection, end with branch
    mem[0] = 16'h2005; mem[1] = 16'hE001; mem[4] = 16'hD0FC; mem[2] = 16'hB480; mem[3] = 16'hDF00;
    run(1000, -1);
    chk("a_first_rd", 32'(seen_rd[0]), 0);
    chk("a_first_word", 32'(seen_val[0]), 32'h2005);
    chk("a_valid_cycle", 32'(first_v), 3);
    chk("a_second_rd", 32'(seen_rd[1]), 1);
    chk("a_bcc_target", 32'(seen_rd[3]), 2);
    chk("a_inject_word", 32'(seen_val[4]), 32'h9701);
    chk("a_post_inject_rd", 32'(seen_rd[4]), 3);
    chk("a_halt_pc", 32'(imem_addr_o), 3);
    chk("a_halted", 32'(halted_o), 1);
`ifdef ISSUE_CNT_EN
    chk("a_issue_cnt", issue_cnt_o, 6);
`endif
    // Backward B and wrap past the top of imem
    clear_mem();
    mem[0] = 16'hE001; mem[3] = 16'hE7FF; mem[4] = 16'hE3F9; mem[1023] = 16'h0001;
    run(4, -1);
    chk("b_back_branch", 32'(seen_rd[2]), 4);
    chk("b_top_addr", 32'(seen_rd[3]), 1023);
    chk("b_wrap_addr", 32'(seen_rd[4]), 0);
    // Self-instruction request held forever: chain overflow
    clear_mem();
    mem[0] = 16'hB4FF;
    run(1000, -1);
    chk("c_valid_words", 32'(seen_val.size()), 9);
    chk("c_err", 32'(err_o), 1);
    chk("c_halted", 32'(halted_o), 1);
    // Restart clears err; non-stalling request ignored; start while busy ignored
    clear_mem();
    mem[0] = 16'hB401; mem[1] = 16'hDF00;
    run(1000, 1);
    chk("d_err_cleared", 32'(err_o), 0);
    chk("d_rd_count", 32'(seen_rd.size()), 2);
    chk("d_halt_pc", 32'(imem_addr_o), 1);
    // Asynchronous reset in the middle of a fetch
    clear_mem();
    mem[0] = 16'h2005;
    @(negedge clk_i);
    stop_after = 1000;
    build(1000);
    start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    rst_n_i = 0;
    #1;
    check_reset("midreset");
    repeat (2) @(negedge clk_i);
    rst_n_i = 1;
    repeat (2) @(negedge clk_i);
    check_reset("after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
